// File: rtl/vdp_pkg.sv
// Shared constants and stage bundles for the text-mode pixel pipeline.
// Palette is a fixed CGA-style 12-bit RGB table.
package vdp_pkg;

  localparam int H_VIS  = 640;
  localparam int V_VIS  = 480;
  localparam int CELL_W = 8;
  localparam int CELL_H = 16;

  localparam int CHAR_LSB = 0;
  localparam int FG_LSB   = 8;
  localparam int BG_LSB   = 12;

  localparam logic [11:0] PALETTE [16] = '{
    12'h000, 12'h00A, 12'h0A0, 12'h0AA,
    12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
    12'h555, 12'h55F, 12'h5F5, 12'h5FF,
    12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
  };

  typedef struct packed {
    logic [2:0] col;
    logic [3:0] lrow;
    logic       vis;
    logic       hs;
    logic       vs;
    logic       hit;
  } s0_t;

  typedef struct packed {
    logic [2:0] col;
    logic [3:0] lrow;
    logic [3:0] fg;
    logic [3:0] bg;
    logic       vis;
    logic       hs;
    logic       vs;
    logic       hit;
  } s1_t;

endpackage

// File: rtl/vdp_cursor_blink.sv
// Cursor cell match and frame-counted blink phase.
// Phase toggles every BLINK_FRAMES falling edges of vsync_in.
module vdp_cursor_blink #(
  parameter int ROWS         = 30,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       dot_clk,
  input  logic       reset,
  input  logic       vsync_in,
  input  logic       cursor_en,
  input  logic [6:0] cursor_col,
  input  logic [4:0] cursor_row,
  input  logic [6:0] cell_col,
  input  logic [4:0] cell_row,
  output logic       cursor_hit,
  output logic       blink_phase
);

  logic       vs_prev_d, vs_prev_q;
  logic [7:0] cnt_d, cnt_q;
  logic       phase_d, phase_q;

  always_comb begin
    vs_prev_d = vsync_in;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    if (vs_prev_q && !vsync_in) begin
      if (cnt_q == 8'(BLINK_FRAMES - 1)) begin
        cnt_d   = 8'd0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge dot_clk) begin
    if (reset) begin
      vs_prev_q <= 1'b1;
      cnt_q     <= 8'd0;
      phase_q   <= 1'b0;
    end else begin
      vs_prev_q <= vs_prev_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
    end
  end

  assign cursor_hit = cursor_en
                    && (cell_col == cursor_col)
                    && (cell_row == cursor_row)
                    && (int'(cell_row) < ROWS);
  assign blink_phase = phase_q;

endmodule

// File: rtl/text_pixel_pipe.sv
// 80x30 text-mode pixel generator: text RAM -> font ROM -> palette,
// three dot_clk cycles from timing inputs to rgb/sync pins.
module text_pixel_pipe
  import vdp_pkg::*;
#(
  parameter int COLS         = H_VIS / CELL_W,
  parameter int ROWS         = V_VIS / CELL_H,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        dot_clk,
  input  logic        reset,
  input  logic [9:0]  column,
  input  logic [8:0]  line,
  input  logic        visible_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [11:0] text_addr,
  input  logic [15:0] text_data,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        hsync,
  output logic        vsync
);

  logic        cursor_hit;
  logic        blink_phase;
  logic [11:0] text_addr_d, text_addr_q;
  logic [11:0] font_addr_d, font_addr_q;
  s0_t         s0_d, s0_q;
  s1_t         s1_d, s1_q;
  logic [11:0] rgb_d, rgb_q;
  logic        hsync_d, hsync_q;
  logic        vsync_d, vsync_q;
  logic        pix;
  logic [3:0]  fg, bg;

  vdp_cursor_blink #(
    .ROWS         (ROWS),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_blink (
    .dot_clk     (dot_clk),
    .reset       (reset),
    .vsync_in    (vsync_in),
    .cursor_en   (cursor_en),
    .cursor_col  (cursor_col),
    .cursor_row  (cursor_row),
    .cell_col    (column[9:3]),
    .cell_row    (line[8:4]),
    .cursor_hit  (cursor_hit),
    .blink_phase (blink_phase)
  );

  always_comb begin
    text_addr_d = 12'(line[8:4]) * 12'(COLS)
                + 12'(column[9:3]);
    s0_d.col  = column[2:0];
    s0_d.lrow = line[3:0];
    s0_d.vis  = visible_in;
    s0_d.hs   = hsync_in;
    s0_d.vs   = vsync_in;
    s0_d.hit  = cursor_hit;

    font_addr_d = {text_data[CHAR_LSB +: 8], s0_q.lrow};
    s1_d.col  = s0_q.col;
    s1_d.lrow = s0_q.lrow;
    s1_d.fg   = text_data[FG_LSB +: 4];
    s1_d.bg   = text_data[BG_LSB +: 4];
    s1_d.vis  = s0_q.vis;
    s1_d.hs   = s0_q.hs;
    s1_d.vs   = s0_q.vs;
    s1_d.hit  = s0_q.hit;

    pix = font_data[3'd7 - s1_q.col];
    fg  = s1_q.fg;
    bg  = s1_q.bg;
    // Block cursor covers the bottom two scanlines of the cell
    if (s1_q.hit && blink_phase && (s1_q.lrow[3:1] == 3'b111)) begin
      fg = s1_q.bg;
      bg = s1_q.fg;
    end
    rgb_d   = s1_q.vis ? PALETTE[pix ? fg : bg] : 12'h000;
    hsync_d = s1_q.hs;
    vsync_d = s1_q.vs;
  end

  always_ff @(posedge dot_clk) begin
    if (reset) begin
      text_addr_q <= 12'd0;
      font_addr_q <= 12'd0;
      s0_q        <= '{col: 3'd0, lrow: 4'd0, vis: 1'b0,
                       hs: 1'b1, vs: 1'b1, hit: 1'b0};
      s1_q        <= '{col: 3'd0, lrow: 4'd0, fg: 4'd0,
                       bg: 4'd0, vis: 1'b0, hs: 1'b1,
                       vs: 1'b1, hit: 1'b0};
      rgb_q       <= 12'h000;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
    end else begin
      text_addr_q <= text_addr_d;
      font_addr_q <= font_addr_d;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      rgb_q       <= rgb_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
    end
  end

  assign text_addr = text_addr_q;
  assign font_addr = font_addr_q;
  assign r         = rgb_q[11:8];
  assign g         = rgb_q[7:4];
  assign b         = rgb_q[3:0];
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;

endmodule
